// File: rtl/alu_execute.sv
// Registered ALU execute stage with a valid/ready request handshake and a flush input.
// Define ALU_MULT_EN to add the iterative shift-add multiplier (opcode 101).
module alu_execute #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock__i,
    input  logic                  reset__i,
    input  logic                  Valid__i,
    input  logic [2:0]            ALUCtrl__i,
    input  logic [DATA_WIDTH-1:0] OperandA__i,
    input  logic [DATA_WIDTH-1:0] OperandB__i,
    input  logic                  Flush__i,
    output logic                  Ready__o,
    output logic                  Valid__o,
    output logic [DATA_WIDTH-1:0] Result__o,
    output logic                  Zero__o,
    output logic                  Overflow__o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam int MSB = DATA_WIDTH - 1;

    logic                  accept;
    logic                  single_go;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  ovf_q;

    assign accept = Valid__i && Ready__o && !Flush__i;
    assign sum    = OperandA__i + OperandB__i;
    assign diff   = OperandA__i - OperandB__i;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl__i)
            OP_AND: alu_res = OperandA__i & OperandB__i;
            OP_OR:  alu_res = OperandA__i | OperandB__i;
            OP_XOR: alu_res = OperandA__i ^ OperandB__i;
            OP_NOR: alu_res = ~(OperandA__i | OperandB__i);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (OperandA__i[MSB] == OperandB__i[MSB]) &&
                          (sum[MSB] != OperandA__i[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (OperandA__i[MSB] != OperandB__i[MSB]) &&
                          (diff[MSB] != OperandA__i[MSB]);
            end
            OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}},
                               $signed(OperandA__i) < $signed(OperandB__i)};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULT_EN
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        MULT
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  is_mul;
    logic                  mul_last;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [CNT_W-1:0]      cnt;

    assign is_mul    = (ALUCtrl__i == OP_MUL);
    assign single_go = accept && !is_mul;
    assign Ready__o  = (state_q == IDLE) && !reset__i;
    assign mul_last  = (cnt == CNT_LAST);
    assign mul_done  = (state_q == MULT) && mul_last && !Flush__i;
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clock__i) begin
        if (reset__i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Flush__i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && is_mul) state_d = MULT;
                MULT:    if (mul_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // One multiplier bit per cycle; only the low DATA_WIDTH product bits are kept.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            acc    <= '0;
            mcand  <= OperandA__i;
            mplier <= OperandB__i;
            cnt    <= '0;
        end else if (state_q == MULT) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    // Opcode 101 falls through the decoder as a one-cycle zero result.
    assign single_go = accept;
    assign Ready__o  = !reset__i;
`endif

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (single_go) begin
                valid_q  <= 1'b1;
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                ovf_q    <= alu_ovf;
            end
`ifdef ALU_MULT_EN
            else if (mul_done) begin
                valid_q  <= 1'b1;
                result_q <= acc_next;
                zero_q   <= (acc_next == '0);
                ovf_q    <= 1'b0;
            end
`endif
        end
    end

    assign Valid__o    = valid_q;
    assign Result__o   = result_q;
    assign Zero__o     = zero_q;
    assign Overflow__o = ovf_q;

endmodule

// File: tb/tb_alu_execute.sv
// Directed-vector bench for alu_execute; multiply tests follow ALU_MULT_EN.
module tb_alu_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        rdy;
    logic        vout;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          checks = 0;
    int          failures = 0;

    alu_execute #(.DATA_WIDTH(32)) dut (
        .clock__i    (clk),
        .reset__i    (rst),
        .Valid__i    (vin),
        .ALUCtrl__i  (ctrl),
        .OperandA__i (a),
        .OperandB__i (b),
        .Flush__i    (flush),
        .Ready__o    (rdy),
        .Valid__o    (vout),
        .Result__o   (res),
        .Zero__o     (zero),
        .Overflow__o (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c,
                         input logic [31:0] x, input logic [31:0] y);
        vin  = v;
        ctrl = c;
        a    = x;
        b    = y;
    endtask

    task automatic expect_out(input string name, input logic ev,
                              input logic [31:0] er, input logic ez,
                              input logic eo);
        checks++;
        if ({vout, res, zero, ovf} !== {ev, er, ez, eo}) begin
            failures++;
            $display("FAIL %s: got v=%b r=%h z=%b o=%b want v=%b r=%h z=%b o=%b",
                     name, vout, res, zero, ovf, ev, er, ez, eo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b want 0", rdy);
        end
        expect_out("reset_outputs", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 1", rdy);
        end
        // Load a nonzero result, then reset with valid and flush both high.
        drive(1'b1, 3'b010, 32'h10, 32'h20);
        tick();
        expect_out("pre_reset_add", 1'b1, 32'h30, 1'b0, 1'b0);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        expect_out("reset_priority", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        expect_out("idle_after_reset", 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_add_sub();
        drive(1'b1, 3'b010, 32'h7FFFFFFF, 32'h1);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_out("add_ovf", 1'b1, 32'h80000000, 1'b0, 1'b1);
        tick();
        expect_out("hold_after_add", 1'b0, 32'h80000000, 1'b0, 1'b1);
        drive(1'b1, 3'b110, 32'h5, 32'h5);
        tick();
        expect_out("sub_zero", 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 3'b111, 32'hFFFFFFFF, 32'h1);
        tick();
        expect_out("slt_signed", 1'b1, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 3'b111, 32'h1, 32'hFFFFFFFF);
        tick();
        expect_out("slt_false", 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 3'b110, 32'h80000000, 32'h1);
        tick();
        expect_out("sub_ovf", 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 32'hFFFFFFFF, 32'h1);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_out("add_wrap", 1'b1, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{3'b000, 3'b001, 3'b011, 3'b100};
        exp = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 32'hF0F0F0F0, 32'hFF00FF00);
            tick();
            expect_out($sformatf("b2b_%0d", i), 1'b1, exp[i], 1'b0, 1'b0);
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, rdy);
            end
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        expect_out("b2b_hold", 1'b0, 32'h000F000F, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 3'b010, 32'h1, 32'h1);
        tick();
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_out("flush_no_accept", 1'b0, 32'h000F000F, 1'b0, 1'b0);
        tick();
        expect_out("flush_no_late", 1'b0, 32'h000F000F, 1'b0, 1'b0);
    endtask

`ifdef ALU_MULT_EN
    task automatic test_mul();
        drive(1'b1, 3'b101, 32'd12345, 32'd678);
        tick();
        // A request held during MULT must never be taken.
        drive(1'b1, 3'b010, 32'h1, 32'h1);
        for (int k = 1; k <= 32; k++) begin
            checks++;
            if (rdy !== 1'b0 || vout !== 1'b0) begin
                failures++;
                $display("FAIL mul_busy_%0d: got rdy=%b v=%b want 0 0",
                         k, rdy, vout);
            end
            if (k == 32) drive(1'b0, 3'b000, 32'h0, 32'h0);
            tick();
        end
        expect_out("mul_result", 1'b1, 32'd8369910, 1'b0, 1'b0);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL mul_ready_after: got %b want 1", rdy);
        end
        tick();
        expect_out("mul_hold", 1'b0, 32'd8369910, 1'b0, 1'b0);
    endtask

    task automatic test_abort(input logic use_reset);
        drive(1'b1, 3'b101, 32'd12345, 32'd678);
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        for (int k = 1; k < 10; k++) tick();
        if (use_reset) rst = 1'b1;
        else           flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        #1;
        if (use_reset)
            expect_out("reset_mul", 1'b0, 32'h0, 1'b0, 1'b0);
        else
            expect_out("flush_mul", 1'b0, 32'd8369910, 1'b0, 1'b0);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready: got %b want 1", rdy);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if (vout !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_pulse_%0d: got v=%b want 0", k, vout);
            end
        end
    endtask
`else
    task automatic test_mul_disabled();
        drive(1'b1, 3'b101, 32'd3, 32'd4);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL nomul_ready_pre: got %b want 1", rdy);
        end
        tick();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        expect_out("nomul_result", 1'b1, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("FAIL nomul_ready_%0d: got %b want 1", k, rdy);
            end
            tick();
        end
        expect_out("nomul_hold", 1'b0, 32'h0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_flush();
`ifdef ALU_MULT_EN
        test_mul();
        test_abort(1'b0);
        test_abort(1'b1);
`else
        test_mul_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_execute.md
ALU_EXECUTE -- requirements
Module: alu_execute

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clock__i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset__i, input, 1 bit, the synchronous active-high reset.
REQ-004 The block SHALL have port Valid__i, input, 1 bit, which marks the operation request as valid.
REQ-005 The block SHALL have port ALUCtrl__i, input, 3 bits, the operation code from the ALU control decoder.
REQ-006 The block SHALL have ports OperandA__i and OperandB__i, input, DATA_WIDTH bits each, the two operands.
REQ-007 The block SHALL have port Flush__i, input, 1 bit, the pipeline flush that aborts in-flight work.
REQ-008 The block SHALL have port Ready__o, output, 1 bit, which is high when a request can be accepted.
REQ-009 The block SHALL have port Valid__o, output, 1 bit, a one-cycle pulse marking a new result.
REQ-010 The block SHALL have port Result__o, output, DATA_WIDTH bits, the registered result.
REQ-011 The block SHALL have port Zero__o, output, 1 bit, registered high when Result__o is all zeros.
REQ-012 The block SHALL have port Overflow__o, output, 1 bit, the registered signed overflow for ADD/SUB; it is 0 for all other operations.

Function
REQ-013 The block SHALL accept a request on any rising edge where Valid__i=1, Ready__o=1 and Flush__i=0.
REQ-014 The block SHALL decode ALUCtrl__i as follows:
- 000 AND
- 001 OR
- 010 ADD
- 110 SUB (A-B)
- 011 XOR
- 100 NOR
- 111 SLT (signed; result 1 or 0, zero-extended)
- 101 MUL (see REQ-021/022)
REQ-015 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH; Overflow__o = 1 when the operand signs imply it and the result sign disagrees.
REQ-016 Single-cycle operations SHALL have latency 1: accepted at edge N, Valid__o=1 with Result__o, Zero__o and Overflow__o valid during cycle N+1.
REQ-017 The FSM SHALL have states IDLE and MULT; Ready__o = (state==IDLE) and reset__i=0.
REQ-018 In IDLE, back-to-back single-cycle requests SHALL be accepted every cycle and produce one Valid__o pulse each.
REQ-019 Result__o, Zero__o and Overflow__o SHALL hold their last values while Valid__o=0.
REQ-020 When Flush__i=1 on an edge, the block SHALL return to IDLE, accept nothing and drive Valid__o=0 next cycle; it SHALL produce no result for an aborted multiply.

Configuration
REQ-021 With ALU_MULT_EN defined, code 101 SHALL enter MULT and perform an iterative shift-add unsigned multiply, one bit per cycle, for DATA_WIDTH cycles.
- The result is the low DATA_WIDTH bits of the product.
- Accepted at edge N, Valid__o=1 during cycle N+DATA_WIDTH+1; IDLE is re-entered on that edge.
- Ready__o=0 throughout MULT.
REQ-022 Without ALU_MULT_EN, code 101 SHALL complete in one cycle with Result__o=0, Zero__o=1, Overflow__o=0; the MULT state and datapath SHALL not be present.

Reset
REQ-023 While reset__i=1 at a rising edge, the block SHALL go to IDLE; on the next cycle Valid__o, Result__o, Zero__o and Overflow__o SHALL all be 0.
REQ-024 Ready__o SHALL be 0 while reset__i=1 and 1 in the first cycle after reset__i is deasserted.
REQ-025 Reset during MULT SHALL abort the multiply with no Valid__o pulse.
REQ-026 Reset SHALL take priority over Flush__i and Valid__i.

Verification
REQ-027 The bench SHALL cover ADD overflow: ADD A=0x7FFFFFFF, B=1 -> next cycle Valid__o=1, Result__o=0x80000000, Overflow__o=1, Zero__o=0.
REQ-028 The bench SHALL cover SUB zero and signed SLT:
- SUB A=5, B=5 -> Result__o=0, Zero__o=1, Overflow__o=0.
- Following cycle, SLT A=0xFFFFFFFF, B=1 -> Result__o=1.
REQ-029 The bench SHALL cover back-to-back throughput: AND, OR, XOR, NOR on consecutive cycles with A=0xF0F0F0F0, B=0xFF00FF00 -> four consecutive Valid__o pulses with results:
- AND 0xF000F000
- OR 0xFFF0FFF0
- XOR 0x0FF00FF0
- NOR 0x000F000F
REQ-030 The bench SHALL cover multiply with ALU_MULT_EN defined: MUL A=12345, B=678 accepted at edge N ->
- Ready__o=0 for 32 cycles.
- Valid__o=1 only in cycle N+33 with Result__o=8369910.
- A Valid__i asserted during MULT is not accepted.
REQ-031 The bench SHALL cover flush and reset mid-multiply:
- Flush__i=1 at cycle N+10 of a MUL -> no Valid__o pulse, Ready__o=1 next cycle.
- Same test with reset__i instead of Flush__i -> all outputs 0.
REQ-032 The bench SHALL cover multiply compiled out: without ALU_MULT_EN, MUL A=3, B=4 -> next cycle Valid__o=1, Result__o=0, Zero__o=1, and Ready__o never drops.
